// File: rtl/column_fetcher_mc_if.sv
// column_fetcher_mc_if: control, ROM and per-channel FIFO signals of column_fetcher_mc
//   master: fetcher side (drives rom_en/rom_addr, out/empty, busy/done)
//   slave : environment side (drives start/cfg_*, rom_data, read)
interface column_fetcher_mc_if #(
  parameter int CHANNELS = 4,
  parameter int COL_W = 16,
  parameter int ADDR_W = 13
);
  logic start;
  logic [CHANNELS*ADDR_W-1:0] cfg_base;
  logic [CHANNELS*ADDR_W-1:0] cfg_len;
  logic rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [COL_W-1:0] rom_data;
  logic [CHANNELS-1:0] read;
  logic [CHANNELS*COL_W-1:0] out;
  logic [CHANNELS-1:0] empty;
  logic busy;
  logic done;
  modport master (
    input start, cfg_base, cfg_len, rom_data, read,
    output rom_en, rom_addr, out, empty, busy, done
  );
  modport slave (
    output start, cfg_base, cfg_len, rom_data, read,
    input rom_en, rom_addr, out, empty, busy, done
  );
endinterface

// File: rtl/column_fetcher_mc.sv
// column_fetcher_mc: streams per-channel column-ID ranges from a shared ROM into show-ahead FIFOs
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : column_fetcher_mc_if.master (start/cfg_*, ROM port, per-channel read/out/empty, busy/done)
//   COLUMN_FETCHER_LOOP_EN: when defined, each channel re-streams its range forever
module column_fetcher_mc #(
  parameter int CHANNELS = 4,
  parameter int COL_W = 16,
  parameter int ADDR_W = 13,
  parameter int FIFO_DEPTH = 8,
  parameter int ROM_LAT = 1
) (
  input logic clk,
  input logic rst,
  column_fetcher_mc_if.master bus
);
  localparam int RW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q [CHANNELS];
  logic [ADDR_W-1:0] remain [CHANNELS];
`ifdef COLUMN_FETCHER_LOOP_EN
  logic [ADDR_W-1:0] base_q [CHANNELS];
  logic [ADDR_W-1:0] len_q [CHANNELS];
`endif
  logic [CW-1:0] credit [CHANNELS];
  logic [FW:0] wptr [CHANNELS];
  logic [FW:0] rptr [CHANNELS];
  logic [COL_W-1:0] mem [CHANNELS][FIFO_DEPTH];
  logic [RW-1:0] rr_ptr, gnt, idx;
  logic gnt_vld, start_ok, pending, done_q;
  logic [ADDR_W-1:0] rom_addr_q;
  // vld/tg[0] is the issue register driving rom_en; stage ROM_LAT lines up with rom_data
  logic [ROM_LAT:0] vld;
  logic [RW-1:0] tg [ROM_LAT+1];
  logic [CHANNELS-1:0] elig, issue, wr, pop, empty_w, full;
  logic [CHANNELS*COL_W-1:0] out_w;
  assign start_ok = state == IDLE && bus.start;
  // done waits only for stages that have not reached the FIFO write yet
  assign pending = |vld[ROM_LAT-1:0];
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // credit counts FIFO occupancy plus requests still in the ROM pipeline
    assign elig[i] = state == RUN && remain[i] != '0 && credit[i] < CW'(FIFO_DEPTH);
    assign issue[i] = gnt_vld && gnt == RW'(i);
    assign wr[i] = vld[ROM_LAT] && tg[ROM_LAT] == RW'(i);
    assign empty_w[i] = wptr[i] == rptr[i];
    assign full[i] = wptr[i] == {~rptr[i][FW], rptr[i][FW-1:0]};
    assign pop[i] = bus.read[i] && !empty_w[i];
    assign out_w[i*COL_W +: COL_W] = empty_w[i] ? '0 : mem[i][rptr[i][FW-1:0]];
    assert property (@(posedge clk) disable iff (!rst) !(wr[i] && full[i]));
  end
  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    gnt = '0;
    gnt_vld = 1'b0;
    idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = RW'((int'(rr_ptr) + k) % CHANNELS);
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt = idx;
      end
    end
  end
`ifdef COLUMN_FETCHER_LOOP_EN
  always_comb begin
    state_nx = state;
    if (start_ok) state_nx = RUN;
  end
`else
  logic all_zero;
  always_comb begin
    all_zero = 1'b1;
    for (int k = 0; k < CHANNELS; k++) all_zero = all_zero && remain[k] == '0;
  end
  always_comb begin
    state_nx = state;
    if (start_ok) state_nx = bus.cfg_len == '0 ? DRAIN : RUN;
    if (state == RUN && all_zero) state_nx = DRAIN;
    if (state == DRAIN && !pending) state_nx = IDLE;
  end
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      vld <= '0;
      done_q <= 1'b0;
      rom_addr_q <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tg[k] <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        addr_q[k] <= '0;
        remain[k] <= '0;
`ifdef COLUMN_FETCHER_LOOP_EN
        base_q[k] <= '0;
        len_q[k] <= '0;
`endif
        credit[k] <= '0;
        wptr[k] <= '0;
        rptr[k] <= '0;
      end
    end else begin
      state <= state_nx;
      done_q <= state == DRAIN && !pending;
      vld <= {vld[ROM_LAT-1:0], gnt_vld};
      tg[0] <= gnt;
      for (int k = 1; k <= ROM_LAT; k++) tg[k] <= tg[k-1];
      if (gnt_vld) begin
        rom_addr_q <= addr_q[gnt];
        rr_ptr <= gnt == RW'(CHANNELS - 1) ? '0 : gnt + RW'(1);
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (start_ok) begin
          addr_q[k] <= bus.cfg_base[k*ADDR_W +: ADDR_W];
          remain[k] <= bus.cfg_len[k*ADDR_W +: ADDR_W];
`ifdef COLUMN_FETCHER_LOOP_EN
          base_q[k] <= bus.cfg_base[k*ADDR_W +: ADDR_W];
          len_q[k] <= bus.cfg_len[k*ADDR_W +: ADDR_W];
`endif
        end else if (issue[k]) begin
`ifdef COLUMN_FETCHER_LOOP_EN
          addr_q[k] <= remain[k] == ADDR_W'(1) ? base_q[k] : addr_q[k] + ADDR_W'(1);
          remain[k] <= remain[k] == ADDR_W'(1) ? len_q[k] : remain[k] - ADDR_W'(1);
`else
          addr_q[k] <= addr_q[k] + ADDR_W'(1);
          remain[k] <= remain[k] - ADDR_W'(1);
`endif
        end
        credit[k] <= credit[k] + CW'(issue[k]) - CW'(pop[k]);
        if (wr[k]) wptr[k] <= wptr[k] + 1'b1;
        if (pop[k]) rptr[k] <= rptr[k] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++)
      if (wr[k]) mem[k][wptr[k][FW-1:0]] <= bus.rom_data;
  end
  assign bus.rom_en = vld[0];
  assign bus.rom_addr = rom_addr_q;
  assign bus.out = out_w;
  assign bus.empty = empty_w;
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
endmodule

// File: tb/tb_column_fetcher_mc.sv
// tb_column_fetcher_mc: scoreboard bench for column_fetcher_mc (ROM_LAT=1 instance u1, ROM_LAT=3 instance u3)
module tb_column_fetcher_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  column_fetcher_mc_if #(.CHANNELS(4), .COL_W(16), .ADDR_W(13)) b1 ();
  column_fetcher_mc_if #(.CHANNELS(4), .COL_W(16), .ADDR_W(13)) b3 ();
  column_fetcher_mc #(.CHANNELS(4), .COL_W(16), .ADDR_W(13), .FIFO_DEPTH(8), .ROM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  column_fetcher_mc #(.CHANNELS(4), .COL_W(16), .ADDR_W(13), .FIFO_DEPTH(8), .ROM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  logic [12:0] r1, r3a, r3b, r3c;
  always_ff @(posedge clk) begin
    r1 <= b1.rom_addr;
    r3a <= b3.rom_addr;
    r3b <= r3a;
    r3c <= r3b;
  end
  assign b1.rom_data = {3'b000, r1};
  assign b3.rom_data = {3'b000, r3c};
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int iss1 = 0;
  int iss3 = 0;
  int done1 = 0;
  int done_cyc1 = 0;
  int en_hist[$];
  logic [12:0] q_addr1[$];
  logic [15:0] q_pop1[$];
  logic [15:0] q_pop3[$];
  always_ff @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h with nothing expected", nm, act);
  endtask
  function automatic logic [51:0] pk(input logic [12:0] a0, input logic [12:0] a1, input logic [12:0] a2, input logic [12:0] a3);
    return {a3, a2, a1, a0};
  endfunction
  // monitor: compares every ROM issue and every FIFO pop against the scoreboard queues
  initial forever begin
    @(negedge clk);
    #1;
    if (b1.rom_en) begin
      iss1++;
      en_hist.push_back(cyc);
      if (q_addr1.size() == 0) fail("u1 unexpected rom_en", 64'(b1.rom_addr));
      else chk("u1 rom_addr", 64'(b1.rom_addr), 64'(q_addr1.pop_front()));
    end
    if (b1.done) begin
      done1++;
      done_cyc1 = cyc;
    end
    for (int i = 0; i < 4; i++)
      if (b1.read[i] && !b1.empty[i]) begin
        if (q_pop1.size() == 0) fail("u1 unexpected pop", 64'(b1.out[i*16 +: 16]));
        else chk("u1 pop head", 64'(b1.out[i*16 +: 16]), 64'(q_pop1.pop_front()));
      end
    if (b3.rom_en) iss3++;
    if (b3.read[0] && !b3.empty[0]) begin
      if (q_pop3.size() == 0) fail("u3 unexpected pop", 64'(b3.out[15:0]));
      else chk("u3 pop head", 64'(b3.out[15:0]), 64'(q_pop3.pop_front()));
    end
  end
  task automatic go(input int u, input logic [51:0] base, input logic [51:0] len);
    @(negedge clk);
    if (u == 1) begin
      b1.cfg_base = base;
      b1.cfg_len = len;
      b1.start = 1'b1;
    end else begin
      b3.cfg_base = base;
      b3.cfg_len = len;
      b3.start = 1'b1;
    end
    @(negedge clk);
    b1.start = 1'b0;
    b3.start = 1'b0;
  endtask
  task automatic pop1(input logic [3:0] m, input int n);
    @(negedge clk);
    b1.read = m;
    repeat (n) @(negedge clk);
    b1.read = '0;
  endtask
  task automatic wait_done1(input int lim, input int d0);
    int n = 0;
    while (done1 == d0 && n < lim) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("done pulse count", 64'(done1), 64'(d0 + 1));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int d, s, k;
    b1.start = 1'b0; b1.read = '0; b1.cfg_base = '0; b1.cfg_len = '0;
    b3.start = 1'b0; b3.read = '0; b3.cfg_base = '0; b3.cfg_len = '0;
    repeat (3) @(negedge clk);
    chk("reset empty", 64'(b1.empty), 64'hF);
    chk("reset busy", 64'(b1.busy), 0);
    chk("reset done", 64'(b1.done), 0);
    chk("reset rom_en", 64'(b1.rom_en), 0);
    chk("reset out", b1.out, 0);
    chk("reset u3 empty", 64'(b3.empty), 64'hF);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle no issue", 64'(iss1), 0);
    // round robin: expected issue order ch0..ch3 twice
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) q_addr1.push_back(13'(c * 16 + r));
    d = done1;
    go(1, pk(13'h000, 13'h010, 13'h020, 13'h030), pk(13'd2, 13'd2, 13'd2, 13'd2));
    wait_done1(40, d);
    chk("rr back-to-back", 64'(en_hist[$] - en_hist[en_hist.size() - 8]), 7);
    chk("done after last write", 64'(done_cyc1 - en_hist[$]), 2);
    chk("rr all issued", 64'(q_addr1.size()), 0);
    chk("busy after done", 64'(b1.busy), 0);
    chk("fifos loaded", 64'(b1.empty), 0);
    q_pop1.push_back(16'h000);
    q_pop1.push_back(16'h001);
    pop1(4'b0001, 2);
    chk("ch0 drained", 64'(b1.empty[0]), 1);
    // all lengths zero
    d = done1;
    go(1, pk(13'h100, 13'h100, 13'h100, 13'h100), '0);
    wait_done1(3, d);
    chk("zero-len busy", 64'(b1.busy), 0);
    // pop on empty, then write and pop together
    q_pop1.push_back(16'h020);
    q_pop1.push_back(16'h021);
    pop1(4'b0100, 2);
    chk("ch2 drained", 64'(b1.empty[2]), 1);
    pop1(4'b0100, 1);
    chk("pop on empty ignored", 64'(b1.empty), 64'b0101);
    q_addr1.push_back(13'h040);
    q_addr1.push_back(13'h041);
    d = done1;
    go(1, pk(13'h000, 13'h000, 13'h040, 13'h000), pk(13'd0, 13'd0, 13'd2, 13'd0));
    k = 0;
    while (b1.empty[2] && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("ch2 filled", 64'(b1.empty[2]), 0);
    q_pop1.push_back(16'h040);
    b1.read = 4'b0100;
    @(negedge clk);
    b1.read = '0;
    chk("pop+write occupancy", 64'(b1.empty[2]), 0);
    chk("pop+write head", 64'(b1.out[47:32]), 64'h041);
    q_pop1.push_back(16'h041);
    b1.read = 4'b0100;
    @(negedge clk);
    b1.read = '0;
    chk("ch2 empty again", 64'(b1.empty[2]), 1);
    wait_done1(10, d);
    // backpressure on the ROM_LAT=3 instance
    go(3, pk(13'h100, 13'h000, 13'h000, 13'h000), pk(13'd20, 13'd0, 13'd0, 13'd0));
    repeat (12) @(negedge clk);
    go(3, pk(13'h200, 13'h200, 13'h200, 13'h200), pk(13'd5, 13'd5, 13'd5, 13'd5));
    repeat (20) @(negedge clk);
    chk("u3 credit limit", 64'(iss3), 8);
    chk("u3 busy", 64'(b3.busy), 1);
    chk("u3 rom_en stalled", 64'(b3.rom_en), 0);
    q_pop3.push_back(16'h100);
    @(negedge clk);
    b3.read = 4'b0001;
    @(negedge clk);
    b3.read = '0;
    repeat (12) @(negedge clk);
    chk("u3 one more issue", 64'(iss3), 9);
    // reset mid-run with two requests in flight
    for (int a = 0; a < 5; a++) q_addr1.push_back(13'(13'h300 + a));
    s = iss1;
    go(1, pk(13'h300, 13'h000, 13'h000, 13'h000), pk(13'd8, 13'd0, 13'd0, 13'd0));
    k = 0;
    while (iss1 - s < 5 && k < 20) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("five issues before reset", 64'(iss1 - s), 5);
    rst = 1'b0;
    #1;
    chk("mid-run reset empty", 64'(b1.empty), 64'hF);
    chk("mid-run reset busy", 64'(b1.busy), 0);
    chk("mid-run reset rom_en", 64'(b1.rom_en), 0);
    chk("mid-run reset u3 empty", 64'(b3.empty), 64'hF);
    repeat (2) @(negedge clk);
    chk("in-flight discarded", 64'(b1.empty), 64'hF);
    rst = 1'b1;
    for (int a = 0; a < 8; a++) q_addr1.push_back(13'(13'h300 + a));
    d = done1;
    go(1, pk(13'h300, 13'h000, 13'h000, 13'h000), pk(13'd8, 13'd0, 13'd0, 13'd0));
    wait_done1(30, d);
    q_pop1.push_back(16'h300);
    pop1(4'b0001, 1);
    repeat (2) @(negedge clk);
    chk("addr queue empty", 64'(q_addr1.size()), 0);
    chk("u1 pop queue empty", 64'(q_pop1.size()), 0);
    chk("u3 pop queue empty", 64'(q_pop3.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
